// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES key-schedule constants, GF(2^8) step helpers and FSM state type
package aes_pkg;

  localparam logic [7:0] RCON_POLY     = 8'h1b;
  localparam logic [7:0] RCON_INV_POLY = 8'h8d;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } rcon_state_t;

  // Multiply by x modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

  // Divide by x modulo the AES polynomial (inverse of xtime).
  function automatic logic [7:0] xinv(input logic [7:0] b);
    return {1'b0, b[7:1]} ^ (b[0] ? RCON_INV_POLY : 8'h00);
  endfunction

  // rcon for round n (1-based); only evaluated on constants, so the loop folds away.
  function automatic logic [7:0] rcon_byte(input int n);
    logic [7:0] b;
    b = 8'h01;
    for (int i = 2; i <= 10; i++) begin
      if (i <= n) b = xtime(b);
    end
    return b;
  endfunction

endpackage

// File: rtl/rcon_seq_if.sv
// rtl/rcon_seq_if.sv - rcon word stream from generator (master) to key-expansion datapath (slave)
interface rcon_seq_if;

  logic        dout_valid;
  logic        dout_ready;
  logic [31:0] dout;
  logic [3:0]  round;
  logic        last;

  modport master (
    output dout_valid,
    output dout,
    output round,
    output last,
    input  dout_ready
  );

  modport slave (
    input  dout_valid,
    input  dout,
    input  round,
    input  last,
    output dout_ready
  );

endinterface

// File: rtl/gf_xstep.sv
// rtl/gf_xstep.sv - combinational one-step rcon walker (forward xtime only with RCON_SEQ_FWD_EN)
module gf_xstep
  import aes_pkg::*;
(
  input  logic [7:0] b_in,
  input  logic       dir,
  output logic [7:0] b_out
);

`ifdef RCON_SEQ_FWD_EN
  // dir=1 walks forward (encrypt order), dir=0 walks backward.
  assign b_out = dir ? xtime(b_in) : xinv(b_in);
`else
  // Backward-only build: the direction select is accepted but has no effect.
  logic unused_dir;
  assign unused_dir = dir;
  assign b_out      = xinv(b_in);
`endif

endmodule

// File: rtl/rcon_seq.sv
// rtl/rcon_seq.sv - sequential AES round-constant generator, backward by default; forward with RCON_SEQ_FWD_EN
module rcon_seq
  import aes_pkg::*;
#(
  parameter int NROUNDS = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        dir,
  output logic        busy,
  rcon_seq_if.master  m
);

  localparam logic [3:0] NR        = 4'(NROUNDS);
  localparam logic [7:0] RCON_LAST = rcon_byte(NROUNDS);

  rcon_state_t state;
  logic [7:0]  rcon_q;
  logic [7:0]  rcon_next;
  logic [3:0]  round_q;
  logic        valid_q;
  logic        busy_q;
  logic        dir_q;
  logic        dir_eff;
  logic        last_w;

`ifdef RCON_SEQ_FWD_EN
  assign dir_eff = dir;
`else
  // Every sequence is backward; the dir pin is tied off here.
  logic unused_dir;
  assign unused_dir = dir;
  assign dir_eff    = 1'b0;
`endif

  gf_xstep u_step (
    .b_in  (rcon_q),
    .dir   (dir_q),
    .b_out (rcon_next)
  );

  // The final word is the one whose round index reaches the end of the walk.
  assign last_w = dir_q ? (round_q == NR) : (round_q == 4'd1);

  // Sequencer: load the first constant on start, step on each accepted word, drop valid after the last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rcon_q  <= 8'h00;
      round_q <= 4'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dir_q   <= dir_eff;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state   <= RUN;
            if (dir_eff) begin
              rcon_q  <= 8'h01;
              round_q <= 4'd1;
            end else begin
              rcon_q  <= RCON_LAST;
              round_q <= NR;
            end
          end
        end
        RUN: begin
          if (valid_q && m.dout_ready) begin
            if (last_w) begin
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              state   <= IDLE;
            end else begin
              rcon_q  <= rcon_next;
              round_q <= dir_q ? round_q + 4'd1 : round_q - 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign m.dout_valid = valid_q;
  assign m.dout       = {rcon_q, 24'h000000};
  assign m.round      = round_q;
  assign m.last       = last_w;

endmodule

// File: tb/tb_rcon_seq.sv
// tb/tb_rcon_seq.sv - randomized self-checking bench for rcon_seq against an rcon-table model
module tb_rcon_seq;

  localparam int N = 10;

`ifdef RCON_SEQ_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic start  = 1'b0;
  logic dir    = 1'b0;
  logic busy;
  logic start1 = 1'b0;
  logic dir1   = 1'b1;
  logic busy1;

  int checks   = 0;
  int failures = 0;

  // Published AES round constants, rounds 1..10.
  logic [7:0] rcon_tab [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  rcon_seq_if sif ();
  rcon_seq_if sif1 ();

  rcon_seq #(.NROUNDS(N)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .dir   (dir),
    .busy  (busy),
    .m     (sif)
  );

  rcon_seq #(.NROUNDS(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .dir   (dir1),
    .busy  (busy1),
    .m     (sif1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the last word was accepted.
  task automatic do_seq(input logic d, input int stall_pct, input bit noise);
    logic de;
    int   idx;
    int   cyc;
    int   er;
    de  = FWD ? d : 1'b0;
    idx = 0;
    cyc = 0;
    start = 1'b1;
    dir   = d;
    @(negedge clk);
    start = 1'b0;
    check("busy_up", 32'(busy), 32'd1);
    check("valid_up", 32'(sif.dout_valid), 32'd1);
    while (idx < N && cyc < 400) begin
      cyc++;
      if (sif.dout_valid) begin
        er = de ? idx + 1 : N - idx;
        check("dout", sif.dout, {rcon_tab[er], 24'h000000});
        check("round", 32'(sif.round), 32'(er));
        check("last", 32'(sif.last), 32'(idx == N - 1));
        check("busy_run", 32'(busy), 32'd1);
      end else begin
        check("valid_run", 32'(sif.dout_valid), 32'd1);
      end
      sif.dout_ready = ($urandom_range(99) >= stall_pct);
      start = noise && ($urandom_range(3) == 0);
      dir   = 1'($urandom);
      if (sif.dout_valid && sif.dout_ready) idx++;
      @(negedge clk);
    end
    start = 1'b0;
    if (idx < N) check("seq_timeout", 32'(idx), 32'(N));
    if (stall_pct == 0) check("cycles", 32'(cyc), 32'(N));
    check("valid_done", 32'(sif.dout_valid), 32'd0);
    check("busy_done", 32'(busy), 32'd0);
    check("round_hold", 32'(sif.round), de ? 32'(N) : 32'd1);
    check("dout_hold", sif.dout, {rcon_tab[de ? N : 1], 24'h000000});
  endtask

  initial begin
    int cyc;
    sif.dout_ready  = 1'b0;
    sif1.dout_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(sif.dout_valid), 32'd0);
    check("rst_dout", sif.dout, 32'd0);
    check("rst_round", 32'(sif.round), 32'd0);
    check("rst_last", 32'(sif.last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_seq(1'b0, 0, 1'b0);
    do_seq(1'b1, 0, 1'b0);
    do_seq(1'b0, 50, 1'b1);
    do_seq(1'b1, 30, 1'b1);
    for (int k = 0; k < 6; k++) begin
      do_seq(1'($urandom), $urandom_range(70), 1'b1);
    end

    // Reset in the middle of a backward sequence.
    start = 1'b1;
    dir   = 1'b0;
    sif.dout_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (sif.round != 4'd5 && cyc < 20) begin
      cyc++;
      @(negedge clk);
    end
    check("reach_r5", 32'(sif.round), 32'd5);
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(sif.dout_valid), 32'd0);
    check("arst_dout", sif.dout, 32'd0);
    check("arst_round", 32'(sif.round), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_idle", 32'(sif.dout_valid), 32'd0);
    end
    do_seq(1'b0, 20, 1'b0);

    // Single-round instance.
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("n1_valid", 32'(sif1.dout_valid), 32'd1);
    check("n1_dout", sif1.dout, 32'h01000000);
    check("n1_round", 32'(sif1.round), 32'd1);
    check("n1_last", 32'(sif1.last), 32'd1);
    check("n1_busy", 32'(busy1), 32'd1);
    sif1.dout_ready = 1'b1;
    @(negedge clk);
    sif1.dout_ready = 1'b0;
    check("n1_valid_done", 32'(sif1.dout_valid), 32'd0);
    check("n1_busy_done", 32'(busy1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
